// File: rtl/prm_occ_driver.sv
// prm_occ_driver: collects occupied-voxel indices of a frame into a 15-bit
// occupancy word for a bank of combinational edge checkers, waits one cycle
// for the checkers to resolve, then captures their edge mask as a result and
// holds it until the consumer takes it.
//
// Optional feature (macro PRM_BLOCKED_CNT_EN): adds output blocked_cnt, the
// population count of res_data, registered together with res_data.
//
// Ports:
//   CLK, RST_n    clock, asynchronous active-low reset
//   vox_valid     occupied-voxel index offered
//   vox_idx       voxel index, 0..14 -> checker inputs A..O, 15 is illegal
//   vox_last      final voxel of the frame (qualified by vox_valid)
//   vox_ready     voxel accepted this cycle
//   occ_vec       occupancy word to the checkers, bit0=A .. bit14=O
//   edge_mask_in  edge_mask outputs of the checker bank, 1 = blocked
//   res_valid     result word available
//   res_data      captured edge mask
//   res_ready     consumer accepts the result
//   idx_err       sticky flag, an index of 15 was received
//   blocked_cnt   (PRM_BLOCKED_CNT_EN only) popcount of res_data
module prm_occ_driver #(
  parameter int unsigned NEDGE = 8
) (
  input  logic                           CLK,
  input  logic                           RST_n,
  input  logic                           vox_valid,
  input  logic [3:0]                     vox_idx,
  input  logic                           vox_last,
  output logic                           vox_ready,
  output logic [14:0]                    occ_vec,
  input  logic [NEDGE-1:0]               edge_mask_in,
  output logic                           res_valid,
  output logic [NEDGE-1:0]               res_data,
  input  logic                           res_ready,
`ifdef PRM_BLOCKED_CNT_EN
  output logic [$clog2(NEDGE+1)-1:0]     blocked_cnt,
`endif
  output logic                           idx_err
);

  localparam int unsigned OCC_W   = 15;
  localparam logic [3:0]  BAD_IDX = 4'd15;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state;

  // Accepted voxel: vox_ready is high exactly while in COLLECT.
  logic vox_acc_c;
  assign vox_acc_c = vox_valid && (state == COLLECT);

`ifdef PRM_BLOCKED_CNT_EN
  localparam int unsigned CNT_W = $clog2(NEDGE + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NEDGE-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(NEDGE); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction
`endif

  // Frame state machine with all outputs registered alongside the state.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= COLLECT;
      vox_ready <= 1'b1;
      occ_vec   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      idx_err   <= 1'b0;
`ifdef PRM_BLOCKED_CNT_EN
      blocked_cnt <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (vox_acc_c) begin
            // Index 15 has no checker input; flag it instead of touching occ_vec.
            if (vox_idx == BAD_IDX) begin
              idx_err <= 1'b1;
            end else begin
              occ_vec <= occ_vec | (OCC_W'(1) << vox_idx);
            end
            if (vox_last) begin
              state     <= SETTLE;
              vox_ready <= 1'b0;
            end
          end
        end

        // One cycle for the combinational checkers to see the final occ_vec.
        SETTLE: begin
          state     <= HOLD;
          res_valid <= 1'b1;
          res_data  <= edge_mask_in;
`ifdef PRM_BLOCKED_CNT_EN
          blocked_cnt <= popcount(edge_mask_in);
`endif
        end

        HOLD: begin
          if (res_ready) begin
            state     <= COLLECT;
            res_valid <= 1'b0;
            vox_ready <= 1'b1;
            occ_vec   <= '0;
          end
        end

        default: begin
          state     <= COLLECT;
          res_valid <= 1'b0;
          vox_ready <= 1'b1;
          occ_vec   <= '0;
        end
      endcase
    end
  end

endmodule
